// File: rtl/program_counter_pkg.sv
// Selector encoding shared by the program counter and its next-value logic.
package program_counter_pkg;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t SEL_NEXT = 2'd0;
  localparam pc_sel_t SEL_KEEP = 2'd1;
  localparam pc_sel_t SEL_LOAD = 2'd2;

endpackage

// File: rtl/program_counter_next.sv
// Combinational next-PC mux: increment, hold or load, plus an all-ones wrap indication.
module program_counter_next
  import program_counter_pkg::*;
#(
  parameter int WORD_SIZE = 15
) (
  input  logic [WORD_SIZE-1:0] i_pc,
  input  pc_sel_t              i_sel,
  input  logic [WORD_SIZE-1:0] i_instruction,
  output logic [WORD_SIZE-1:0] o_next,
  output logic                 o_wrap
);

  always_comb begin
    o_next = i_pc;
    o_wrap = 1'b0;
    // Reserved or unknown selector values fall through to hold.
    case (i_sel)
      SEL_NEXT: begin
        o_next = i_pc + 1'b1;
        o_wrap = &i_pc;
      end
      SEL_LOAD: o_next = i_instruction;
      default:  o_next = i_pc;
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// Program counter register with synchronous reset.
// Optional `wrapped` output under PROGRAM_COUNTER_WRAP_FLAG_EN.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int                   WORD_SIZE   = 15,
  parameter logic [WORD_SIZE-1:0] RESET_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           selector,
  input  logic [WORD_SIZE-1:0] instruction,
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
  output logic                 wrapped,
`endif
  output logic [WORD_SIZE-1:0] out
);

  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] w_next;

`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
  logic w_wrap;
  logic r_wrapped;
`else
  logic w_wrap_unused;
`endif

  program_counter_next #(.WORD_SIZE(WORD_SIZE)) u_next (
    .i_pc          (r_pc),
    .i_sel         (pc_sel_t'(selector)),
    .i_instruction (instruction),
    .o_next        (w_next),
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
    .o_wrap        (w_wrap)
`else
    .o_wrap        (w_wrap_unused)
`endif
  );

  always_ff @(posedge clock) begin
    if (reset) r_pc <= RESET_VALUE;
    else       r_pc <= w_next;
  end

`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
  always_ff @(posedge clock) begin
    if (reset) r_wrapped <= 1'b0;
    else       r_wrapped <= w_wrap;
  end

  assign wrapped = r_wrapped;
`endif

  assign out = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus random mix vs an arithmetic model.
module tb_program_counter;

  localparam int W   = 15;
  localparam int MOD = 1 << W;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   selector = 2'd1;
  logic [W-1:0] instruction = '0;
  logic [W-1:0] out;
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
  logic         wrapped;
`endif

  int nchecks = 0;
  int nerr    = 0;
  int exp_pc  = 0;
  bit exp_wrap = 1'b0;

  program_counter #(.WORD_SIZE(W), .RESET_VALUE('0)) dut (
    .clock       (clock),
    .reset       (reset),
    .selector    (selector),
    .instruction (instruction),
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
    .wrapped     (wrapped),
`endif
    .out         (out)
  );

  always #5 clock = ~clock;

  task automatic step(input string tag, input bit rst, input int sel, input int ins);
    int old;
    reset       = rst;
    selector    = 2'(sel);
    instruction = W'(ins);
    @(posedge clock);
    old = exp_pc;
    exp_wrap = 1'b0;
    if (rst) exp_pc = 0;
    else if (sel == 0) begin
      exp_pc   = (old + 1) % MOD;
      exp_wrap = (old == MOD - 1);
    end
    else if (sel == 2) exp_pc = ins % MOD;
    @(negedge clock);
    nchecks++;
    assert (out === W'(exp_pc))
      else begin
        nerr++;
        $error("FAIL %s t=%0t out=%h expected=%h reset=%b selector=%0d instruction=%h",
               tag, $time, out, W'(exp_pc), rst, sel, W'(ins));
      end
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
    nchecks++;
    assert (wrapped === exp_wrap)
      else begin
        nerr++;
        $error("FAIL %s_wrapped t=%0t wrapped=%b expected=%b out=%h", tag, $time, wrapped, exp_wrap, out);
      end
`endif
  endtask

  initial begin
    @(negedge clock);

    // 1: reset then count 1..9; also hold reset across several edges
    step("rst", 1, 0, 0);
    step("rst_hold", 1, 0, 16'h1234);
    step("rst_hold", 1, 2, 16'h0555);
    for (int i = 0; i < 9; i++) step("count", 0, 0, 0);

    // 2: random loads
    for (int i = 0; i < 10; i++) step("load_rand", 0, 2, int'($urandom_range(0, MOD - 1)));

    // 3: load then keep, then reset during keep
    step("load_1234", 0, 2, 'h1234);
    for (int i = 0; i < 5; i++) step("keep", 0, 1, int'($urandom_range(0, MOD - 1)));
    step("rst_keep", 1, 1, 0);
    step("rst_keep2", 1, 1, 0);
    step("after_rst_keep", 0, 1, 'h7777);

    // 4: wrap from all-ones, then no flag after KEEP or a LOAD of 0
    step("load_7fff", 0, 2, 'h7FFF);
    step("wrap", 0, 0, 0);
    step("post_wrap", 0, 0, 0);
    step("load_7fff_b", 0, 2, 'h7FFF);
    step("wrap_b", 0, 0, 0);
    step("keep_after_wrap", 0, 1, 0);
    step("load_7fff_c", 0, 2, 'h7FFF);
    step("load_zero", 0, 2, 0);

    // 5: reserved selector holds; reset beats LOAD; count resumes 0 -> 1
    step("load_0042", 0, 2, 'h0042);
    step("sel3", 0, 3, 'h5555);
    step("sel3_b", 0, 3, 'h2AAA);
    step("rst_vs_load", 1, 2, 'h1111);
    step("next_after_rst", 0, 0, 0);

    // random mix including occasional resets and near-wrap loads
    for (int i = 0; i < 200; i++) begin
      int sel;
      int ins;
      bit rst;
      rst = ($urandom_range(0, 15) == 0);
      sel = int'($urandom_range(0, 3));
      ins = ($urandom_range(0, 3) == 0) ? MOD - 1 - int'($urandom_range(0, 2))
                                        : int'($urandom_range(0, MOD - 1));
      step("random", rst, sel, ins);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

endmodule
